rr_mux_scanner: RTL and testbench
=================================

# rr_mux_scanner

Sequential control stage that drives the 2-bit select of `four_one_mux` and consumes its 4-bit `dout`. It arbitrates four requesting channels round-robin, steers the mux to the winner, registers the selected word and presents it downstream on a valid/ready handshake. It also pulses a per-channel acknowledge and keeps a transfer count.

## Interface
Parameters:
- `DATA_W`, 4: data width; must match the mux bus width.
- `CNT_W`, 8: width of the transfer counter.

Ports:
- `clk`  in  1  single clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous and active-high.
- `req`  in  4  per-channel request; bit i corresponds to mux input i (a=0, b=1, c=2, d=3).
- `sel`  out  2  registered select to `four_one_mux.s`.
- `mux_dout`  in  DATA_W  word returned from `four_one_mux.dout`.
- `ack`  out  4  one-hot, one-cycle pulse when the channel's word is captured.
- `out_data`  out  DATA_W  captured word.
- `out_valid`  out  1  `out_data` holds an untransferred word.
- `out_ready`  in  1  downstream accepts the word.
- `xfer_cnt`  out  CNT_W  count of completed handshakes.

## Operation
- State machine with states IDLE, SAMPLE and WAIT.
- **IDLE**
  - If `req` is nonzero, select the winner: the first set bit scanning upward from `last+1`, modulo 4.
  - Load `sel` with the winner, set `last` to the winner and go to SAMPLE.
  - Otherwise stay in IDLE with `sel` unchanged.
- **SAMPLE**
  - The mux has settled on the registered `sel`.
  - Capture `mux_dout` into `out_data`.
  - Set `out_valid`=1 and `ack`=onehot(winner) for this edge only.
  - Go to WAIT.
- **WAIT**
  - Hold `out_data`, `out_valid` and `sel`.
  - When `out_valid && out_ready`, clear `out_valid`, increment `xfer_cnt` and go to IDLE.
- Arbitration rules:
  - `req` is sampled only in IDLE.
  - Deassertion after grant does not cancel the capture.
  - Requests arriving in SAMPLE/WAIT wait for the next IDLE.
- `xfer_cnt` wraps from 2^CNT_W−1 to 0 with no saturation.
- If only one channel requests, it wins repeatedly; there is no starvation of others, because the pointer advances past each winner.
- Reset values:
  - `sel`=0, `last`=3 (so the first scan starts at channel 0).
  - `out_data`=0, `out_valid`=0, `ack`=0, `xfer_cnt`=0, state IDLE.
- Reset mid-operation: `rst` overrides every state. A pending `out_valid` word is dropped without counting, and the pointer returns to its reset value.

## Timing
- Edge E0: IDLE samples a nonzero `req`; `sel` is valid after E0.
- Edge E1: `mux_dout` is captured; `out_valid`=1 and `ack` are high for exactly the cycle after E1.
- Request-to-valid latency is 2 cycles.
- If `out_ready`=1 in the first valid cycle, the handshake completes at E2 and the FSM re-enters IDLE after E2.
- Minimum transfer period is 3 cycles.
- `out_data` and `sel` remain stable while `out_valid`=1 and `out_ready`=0, for any number of cycles.
- `ack` never asserts in more than one bit and never for more than one cycle per grant.
- `out_ready` has no effect while `out_valid`=0.

## Structure
- Shared package `mux_sel_pkg`:
  - `NUM_CH`=4 and `SEL_W`=2.
  - State enum `scan_state_t` {IDLE, SAMPLE, WAIT}.
  - Function `onehot_sel(sel)` returning a 4-bit one-hot.
- One sub-module, `rr_next_ptr`: combinational round-robin finder. Inputs are `req[3:0]` and `last[1:0]`; outputs are `next[1:0]` and `found`.
- The top level contains the FSM, the registers and the counter.
- The top level does not instantiate `four_one_mux`; the integrating level connects `sel`/`mux_dout`.

## Test plan
- Reset: hold `rst` for 2 cycles with random `req` → `sel`=00, `out_valid`=0, `ack`=0000, `xfer_cnt`=0, and nothing asserts until `rst` falls.
- Single request:
  - Stimulus: `req`=0100, bench mux model returns c=4'hA, `out_ready`=1.
  - Response: `sel`=10 one cycle later; `out_data`=A and `out_valid`=1 with `ack`=0100 two cycles after `req`; `xfer_cnt`=1.
- Fairness: `req`=1111 and `out_ready`=1 for 15 cycles → grant order 0,1,2,3,0, with one grant every 3 cycles.
- Backpressure: `out_ready`=0 for 5 cycles after valid → `out_data`, `sel` and `out_valid` stable; `ack` only in the first cycle; no new `sel`. Raising `out_ready` completes the transfer in that cycle.
- Reset in WAIT: assert `rst` while `out_valid`=1 → all outputs return to reset values after the next edge, `xfer_cnt` is unchanged from 0 reset, and the next `req`=1111 grants channel 0.
- Counter wrap: 256 completed transfers with `CNT_W`=8 → `xfer_cnt` reads 255, then 0.

Source files
------------

// File: rtl/mux_sel_pkg.sv
// Shared definitions for the round-robin mux scanner: channel count, select width,
// FSM state type and the select-to-one-hot helper.
package mux_sel_pkg;

    localparam int NUM_CH = 4;
    localparam int SEL_W  = 2;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        WAIT   = 2'd2
    } scan_state_t;

    function automatic logic [NUM_CH-1:0] onehot_sel(input logic [SEL_W-1:0] sel);
        return NUM_CH'(1) << sel;
    endfunction

endpackage

// File: rtl/rr_next_ptr.sv
// Combinational round-robin finder: first requesting channel strictly after `last`,
// wrapping modulo NUM_CH.
module rr_next_ptr
    import mux_sel_pkg::*;
(
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  last,
    output logic [SEL_W-1:0]  next,
    output logic              found
);

    logic [SEL_W-1:0] idx;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        next  = last;
        found = 1'b0;
        idx   = last;
        // Offsets 1..NUM_CH visit last+1 first and last itself at the very end.
        for (int i = 1; i <= NUM_CH; i++) begin
            idx = last + SEL_W'(i);
            if (!found && req[idx]) begin
                next  = idx;
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/rr_mux_scanner.sv
// Round-robin scanner: grants one of four requesters, steers the external 4:1 mux,
// captures its word and hands it downstream over valid/ready while counting transfers.
module rr_mux_scanner
    import mux_sel_pkg::*;
#(
    parameter int DATA_W = 4,
    parameter int CNT_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] req,
    output logic [SEL_W-1:0]  sel,
    input  logic [DATA_W-1:0] mux_dout,
    output logic [NUM_CH-1:0] ack,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_cnt
);

    scan_state_t       state_q,     state_d;
    logic [SEL_W-1:0]  sel_q,       sel_d;
    logic [SEL_W-1:0]  last_q,      last_d;
    logic [DATA_W-1:0] out_data_q,  out_data_d;
    logic              out_valid_q, out_valid_d;
    logic [NUM_CH-1:0] ack_q,       ack_d;
    logic [CNT_W-1:0]  xfer_cnt_q,  xfer_cnt_d;

    logic [SEL_W-1:0]  next_ch;
    logic              found;

    rr_next_ptr u_next_ptr (
        .req   (req),
        .last  (last_q),
        .next  (next_ch),
        .found (found)
    );

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        last_d      = last_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        ack_d       = '0;
        xfer_cnt_d  = xfer_cnt_q;

        case (state_q)
            IDLE: begin
                if (found) begin
                    sel_d   = next_ch;
                    last_d  = next_ch;
                    state_d = SAMPLE;
                end
            end
            // The mux has had a full cycle to settle on sel_q before capture.
            SAMPLE: begin
                out_data_d  = mux_dout;
                out_valid_d = 1'b1;
                ack_d       = onehot_sel(sel_q);
                state_d     = WAIT;
            end
            WAIT: begin
                if (out_valid_q && out_ready) begin
                    out_valid_d = 1'b0;
                    xfer_cnt_d  = xfer_cnt_q + CNT_W'(1);
                    state_d     = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // last_q resets to the top channel so the first scan begins at channel 0.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            last_q      <= SEL_W'(NUM_CH - 1);
            out_data_q  <= '0;
            out_valid_q <= 1'b0;
            ack_q       <= '0;
            xfer_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            last_q      <= last_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            ack_q       <= ack_d;
            xfer_cnt_q  <= xfer_cnt_d;
        end
    end

    assign sel       = sel_q;
    assign ack       = ack_q;
    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign xfer_cnt  = xfer_cnt_q;

endmodule

// File: tb/tb_rr_mux_scanner.sv
// Self-checking bench for rr_mux_scanner: a behavioural 4:1 mux plus a transaction-level
// round-robin model predict every select, capture, acknowledge and count.
module tb_rr_mux_scanner;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] req;
    logic [1:0] sel;
    logic [3:0] mux_dout;
    logic [3:0] ack;
    logic [3:0] out_data;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] xfer_cnt;

    logic [3:0] words [4];

    int         errors = 0;
    int         checks = 0;

    int         m_last;
    logic [1:0] m_sel;
    logic [7:0] m_cnt;

    rr_mux_scanner #(.DATA_W(4), .CNT_W(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .req       (req),
        .sel       (sel),
        .mux_dout  (mux_dout),
        .ack       (ack),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .xfer_cnt  (xfer_cnt)
    );

    assign mux_dout = words[sel];

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic int rr_pick(input logic [3:0] r, input int last);
        for (int k = 1; k <= 4; k++) begin
            if (r[(last + k) % 4]) return (last + k) % 4;
        end
        return -1;
    endfunction

    task automatic randomize_words();
        for (int i = 0; i < 4; i++) words[i] = 4'($urandom);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        out_ready = 1'b0;
        req = 4'h0;
        step();
        step();
        rst = 1'b0;
        m_last = 3;
        m_sel = 2'd0;
        m_cnt = 8'd0;
    endtask

    // One full grant: request, capture, optional stall, handshake.
    task automatic run_grant(input logic [3:0] r, input int stall, input bit drop_req);
        int w;
        logic [3:0] exp_ack;
        logic [3:0] exp_data;
        w = rr_pick(r, m_last);
        randomize_words();
        req = r;
        out_ready = 1'b0;
        step();
        checks++;
        if (sel !== 2'(w) || out_valid !== 1'b0 || ack !== 4'h0) begin
            errors++;
            $display("FAIL grant_sel: sel=%0d valid=%0b ack=%b, expected sel=%0d valid=0 ack=0000", sel, out_valid, ack, w);
        end
        m_last = w;
        m_sel = 2'(w);
        req = drop_req ? 4'h0 : 4'($urandom);
        step();
        exp_ack = 4'b0001 << w;
        exp_data = words[w];
        checks++;
        if (out_valid !== 1'b1 || ack !== exp_ack || out_data !== exp_data) begin
            errors++;
            $display("FAIL capture: valid=%0b ack=%b data=%h, expected valid=1 ack=%b data=%h", out_valid, ack, out_data, exp_ack, exp_data);
        end
        randomize_words();
        for (int s = 0; s < stall; s++) begin
            req = 4'($urandom);
            step();
            checks++;
            if (out_valid !== 1'b1 || ack !== 4'h0 || out_data !== exp_data || sel !== m_sel || xfer_cnt !== m_cnt) begin
                errors++;
                $display("FAIL stall: valid=%0b ack=%b data=%h sel=%0d cnt=%0d, expected valid=1 ack=0000 data=%h sel=%0d cnt=%0d",
                         out_valid, ack, out_data, sel, xfer_cnt, exp_data, m_sel, m_cnt);
            end
        end
        out_ready = 1'b1;
        step();
        m_cnt = m_cnt + 8'd1;
        checks++;
        if (out_valid !== 1'b0 || ack !== 4'h0 || xfer_cnt !== m_cnt || sel !== m_sel) begin
            errors++;
            $display("FAIL handshake: valid=%0b ack=%b cnt=%0d sel=%0d, expected valid=0 ack=0000 cnt=%0d sel=%0d", out_valid, ack, xfer_cnt, sel, m_cnt, m_sel);
        end
        out_ready = 1'b0;
        req = 4'h0;
    endtask

    task automatic idle_cycle();
        req = 4'h0;
        out_ready = 1'($urandom);
        step();
        checks++;
        if (sel !== m_sel || out_valid !== 1'b0 || ack !== 4'h0 || xfer_cnt !== m_cnt) begin
            errors++;
            $display("FAIL idle: sel=%0d valid=%0b ack=%b cnt=%0d, expected sel=%0d valid=0 ack=0000 cnt=%0d", sel, out_valid, ack, xfer_cnt, m_sel, m_cnt);
        end
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        randomize_words();
        rst = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < 2; i++) begin
            req = 4'($urandom_range(1, 15));
            step();
            checks++;
            if (sel !== 2'd0 || out_valid !== 1'b0 || ack !== 4'h0 || xfer_cnt !== 8'd0 || out_data !== 4'h0) begin
                errors++;
                $display("FAIL reset_hold: sel=%0d valid=%0b ack=%b cnt=%0d data=%h, expected all zero", sel, out_valid, ack, xfer_cnt, out_data);
            end
        end
        rst = 1'b0;
        m_last = 3;
        m_sel = 2'd0;
        m_cnt = 8'd0;
        idle_cycle();
    endtask

    task automatic test_single();
        do_reset();
        randomize_words();
        words[2] = 4'hA;
        req = 4'b0100;
        out_ready = 1'b1;
        step();
        checks++;
        if (sel !== 2'b10 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL single_sel: sel=%b valid=%0b, expected sel=10 valid=0", sel, out_valid);
        end
        step();
        checks++;
        if (out_data !== 4'hA || out_valid !== 1'b1 || ack !== 4'b0100) begin
            errors++;
            $display("FAIL single_capture: data=%h valid=%0b ack=%b, expected data=a valid=1 ack=0100", out_data, out_valid, ack);
        end
        step();
        req = 4'h0;
        out_ready = 1'b0;
        checks++;
        if (xfer_cnt !== 8'd1 || out_valid !== 1'b0 || ack !== 4'h0) begin
            errors++;
            $display("FAIL single_count: cnt=%0d valid=%0b ack=%b, expected cnt=1 valid=0 ack=0000", xfer_cnt, out_valid, ack);
        end
        m_last = 2;
        m_sel = 2'd2;
        m_cnt = 8'd1;
    endtask

    task automatic test_fairness();
        logic [3:0] exp_ack;
        do_reset();
        randomize_words();
        req = 4'hF;
        out_ready = 1'b1;
        for (int i = 1; i <= 15; i++) begin
            step();
            exp_ack = (i % 3 == 2) ? (4'b0001 << (((i - 2) / 3) % 4)) : 4'h0;
            checks++;
            if (ack !== exp_ack) begin
                errors++;
                $display("FAIL fairness cycle %0d: ack=%b, expected %b", i, ack, exp_ack);
            end
        end
        req = 4'h0;
        out_ready = 1'b0;
        checks++;
        if (xfer_cnt !== 8'd5) begin
            errors++;
            $display("FAIL fairness_count: cnt=%0d, expected 5", xfer_cnt);
        end
        m_last = 0;
        m_sel = 2'd0;
        m_cnt = 8'd5;
    endtask

    task automatic test_backpressure();
        run_grant(4'b1000, 5, 1'b1);
        run_grant(4'b1001, 3, 1'b0);
    endtask

    task automatic test_reset_in_wait();
        do_reset();
        randomize_words();
        req = 4'b0010;
        step();
        req = 4'h0;
        step();
        step();
        checks++;
        if (out_valid !== 1'b1 || sel !== 2'd1) begin
            errors++;
            $display("FAIL wait_setup: valid=%0b sel=%0d, expected valid=1 sel=1", out_valid, sel);
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++;
        if (sel !== 2'd0 || out_valid !== 1'b0 || ack !== 4'h0 || out_data !== 4'h0 || xfer_cnt !== 8'd0) begin
            errors++;
            $display("FAIL reset_in_wait: sel=%0d valid=%0b ack=%b data=%h cnt=%0d, expected all zero", sel, out_valid, ack, out_data, xfer_cnt);
        end
        m_last = 3;
        m_sel = 2'd0;
        m_cnt = 8'd0;
        run_grant(4'hF, 0, 1'b0);
        checks++;
        if (m_last != 0 || xfer_cnt !== 8'd1) begin
            errors++;
            $display("FAIL post_reset_grant: winner=%0d cnt=%0d, expected winner=0 cnt=1", m_last, xfer_cnt);
        end
    endtask

    task automatic test_counter_wrap();
        do_reset();
        for (int n = 1; n <= 256; n++) begin
            run_grant(4'($urandom_range(1, 15)), 0, 1'($urandom));
            if (n == 255) begin
                checks++;
                if (xfer_cnt !== 8'd255) begin
                    errors++;
                    $display("FAIL wrap_255: cnt=%0d, expected 255", xfer_cnt);
                end
            end
            if (n == 256) begin
                checks++;
                if (xfer_cnt !== 8'd0) begin
                    errors++;
                    $display("FAIL wrap_0: cnt=%0d, expected 0", xfer_cnt);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 3) == 0) idle_cycle();
            else run_grant(4'($urandom_range(1, 15)), int'($urandom_range(0, 4)), 1'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req = 4'h0;
        out_ready = 1'b0;
        randomize_words();
        test_reset();
        test_single();
        test_fairness();
        test_backpressure();
        test_reset_in_wait();
        test_counter_wrap();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
